// File: rtl/trace_read_sequencer.sv
// MMIO-side sequencer sharing one read_controls/trace_rvalid bus among up to 16 trace arrays.
// Build option: define TRACE_AUTO_STOP_EN to set the trace-stop bit on every accepted read.
module trace_read_sequencer #(
    parameter int unsigned NUM_TRACES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [63:0] ERR_DATA       = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_mmio_req,
    input  logic [3:0]                 i_mmio_trace_id,
    input  logic                       i_mmio_stop,
    output logic                       o_mmio_busy,
    output logic                       o_mmio_ack,
    output logic                       o_mmio_err,
    output logic [63:0]                o_mmio_data,
    output logic [21:17]               o_read_controls,
    output logic                       o_trace_rvalid,
    input  logic [64*NUM_TRACES-1:0]   i_trace_data_in,
    input  logic [NUM_TRACES-1:0]      i_trace_ack_in
);

`ifdef TRACE_AUTO_STOP_EN
    localparam bit AUTO_STOP = 1'b1;
`else
    localparam bit AUTO_STOP = 1'b0;
`endif

    // state   | meaning
    // S_IDLE  | waiting for an MMIO read request
    // S_ISSUE | one-cycle rvalid strobe with target ID on read_controls
    // S_WAIT  | waiting for the addressed array's ack, timeout running
    // S_RESP  | one-cycle mmio_ack with data/err
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_id;
    logic [3:0]  r_ctl_id;
    logic [7:0]  r_cnt;
    logic        r_stop;

    logic        w_id_ok;
    logic        w_ack_sel;
    logic [63:0] w_data_sel;

    assign w_id_ok         = (32'(i_mmio_trace_id) < NUM_TRACES);
    assign o_read_controls = {r_stop, r_ctl_id};

    always_comb begin
        w_ack_sel  = 1'b0;
        w_data_sel = '0;
        for (int k = 0; k < int'(NUM_TRACES); k++) begin
            if (r_id == 4'(k)) begin
                w_ack_sel  = i_trace_ack_in[k];
                w_data_sel = i_trace_data_in[64*k +: 64];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_id           <= '0;
            r_ctl_id       <= '0;
            r_cnt          <= '0;
            r_stop         <= 1'b0;
            o_mmio_busy    <= 1'b0;
            o_mmio_ack     <= 1'b0;
            o_mmio_err     <= 1'b0;
            o_mmio_data    <= '0;
            o_trace_rvalid <= 1'b0;
        end else begin
            o_mmio_ack     <= 1'b0;
            o_mmio_err     <= 1'b0;
            o_trace_rvalid <= 1'b0;
            r_ctl_id       <= '0;
            if (i_mmio_stop) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_mmio_req) begin
                        o_mmio_busy <= 1'b1;
                        if (w_id_ok) begin
                            r_id           <= i_mmio_trace_id;
                            r_ctl_id       <= i_mmio_trace_id;
                            o_trace_rvalid <= 1'b1;
                            r_state        <= S_ISSUE;
                            if (AUTO_STOP) begin
                                r_stop <= 1'b1;
                            end
                        end else begin
                            o_mmio_ack  <= 1'b1;
                            o_mmio_err  <= 1'b1;
                            o_mmio_data <= ERR_DATA;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack arriving on the last allowed WAIT cycle still wins over the timeout.
                    if (w_ack_sel) begin
                        o_mmio_ack  <= 1'b1;
                        o_mmio_data <= w_data_sel;
                        r_state     <= S_RESP;
                    end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        o_mmio_ack  <= 1'b1;
                        o_mmio_err  <= 1'b1;
                        o_mmio_data <= ERR_DATA;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_cnt       <= '0;
                    o_mmio_busy <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    o_mmio_busy <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_read_sequencer.sv
// Self-checking bench for trace_read_sequencer: scoreboard of expected MMIO responses plus per-scenario tasks.
module tb_trace_read_sequencer;

    localparam int NT  = 4;
    localparam int TMO = 64;
    localparam logic [63:0] ERRD = 64'hDEAD_BEEF_DEAD_BEEF;

`ifdef TRACE_AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic            mmio_req;
    logic [3:0]      mmio_trace_id;
    logic            mmio_stop;
    logic            mmio_busy;
    logic            mmio_ack;
    logic            mmio_err;
    logic [63:0]     mmio_data;
    logic [21:17]    read_controls;
    logic            trace_rvalid;
    logic [64*NT-1:0] trace_data_in;
    logic [NT-1:0]   trace_ack_in;

    logic [63:0]     arr_data [NT];
    logic [NT-1:0]   resp_en;
    logic [NT-1:0]   ack_model;
    logic [NT-1:0]   spur_ack;

    typedef struct {
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rv_cnt = 0;

    trace_read_sequencer #(
        .NUM_TRACES(NT),
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA(ERRD)
    ) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .i_mmio_req(mmio_req),
        .i_mmio_trace_id(mmio_trace_id),
        .i_mmio_stop(mmio_stop),
        .o_mmio_busy(mmio_busy),
        .o_mmio_ack(mmio_ack),
        .o_mmio_err(mmio_err),
        .o_mmio_data(mmio_data),
        .o_read_controls(read_controls),
        .o_trace_rvalid(trace_rvalid),
        .i_trace_data_in(trace_data_in),
        .i_trace_ack_in(trace_ack_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: addressed, enabled array acks one cycle after rvalid.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_model <= '0;
        end else begin
            for (int k = 0; k < NT; k++)
                ack_model[k] <= trace_rvalid && (read_controls[20:17] == 4'(k)) && resp_en[k];
        end
    end

    assign trace_ack_in  = ack_model | spur_ack;
    assign trace_data_in = {arr_data[3], arr_data[2], arr_data[1], arr_data[0]};

    always @(negedge clk) begin
        if (trace_rvalid === 1'b1) rv_cnt++;
        if (mmio_ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got mmio_ack=1 at cycle %0d, required no ack", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (mmio_err !== e.err) begin
                    errors++;
                    $display("FAIL resp_err: got %b, required %b", mmio_err, e.err);
                end
                checks++;
                if (mmio_data !== e.data) begin
                    errors++;
                    $display("FAIL resp_data: got %h, required %h", mmio_data, e.data);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL resp_cycle: got %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue_req(input logic [3:0] id, input bit push, input logic err,
                             input logic [63:0] data, input int lat, output int t);
        exp_t e;
        @(negedge clk);
        mmio_req      = 1'b1;
        mmio_trace_id = id;
        t             = cyc;
        if (push) begin
            e.err  = err;
            e.data = data;
            e.cyc  = t + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        mmio_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mmio_busy !== 1'b0 || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle: busy=%b pending=%0d after %0d cycles, required idle", mmio_busy, sb.size(), n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({mmio_busy, mmio_ack, mmio_err, trace_rvalid} !== 4'b0 || mmio_data !== 64'd0 || read_controls !== 5'd0) begin
            errors++;
            $display("FAIL %s: busy=%b ack=%b err=%b rvalid=%b data=%h ctl=%b, required all 0",
                     tag, mmio_busy, mmio_ack, mmio_err, trace_rvalid, mmio_data, read_controls);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_good_read();
        int t;
        issue_req(4'd2, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 3, t);
        checks++;
        if (trace_rvalid !== 1'b1 || read_controls[20:17] !== 4'b0010 || mmio_busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_cycle: rvalid=%b id=%b busy=%b, required 1 0010 1", trace_rvalid, read_controls[20:17], mmio_busy);
        end
        checks++;
        if (read_controls[21] !== AUTO) begin
            errors++;
            $display("FAIL auto_stop: got %b, required %b", read_controls[21], AUTO);
        end
        @(negedge clk);
        checks++;
        if (trace_rvalid !== 1'b0 || read_controls[20:17] !== 4'b0000) begin
            errors++;
            $display("FAIL after_issue: rvalid=%b id=%b, required 0 0000", trace_rvalid, read_controls[20:17]);
        end
        wait_idle();
    endtask

    task automatic test_bad_id();
        int t;
        int rv0;
        rv0 = rv_cnt;
        issue_req(4'd7, 1'b1, 1'b1, ERRD, 1, t);
        wait_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (rv_cnt !== rv0) begin
            errors++;
            $display("FAIL bad_id_rvalid: got %0d strobes, required 0", rv_cnt - rv0);
        end
    endtask

    task automatic test_timeout();
        int t;
        resp_en[1] = 1'b0;
        issue_req(4'd1, 1'b1, 1'b1, ERRD, TMO + 2, t);
        wait_idle();
        resp_en[1] = 1'b1;
    endtask

    task automatic test_back_to_back();
        int t;
        int rv0;
        rv0 = rv_cnt;
        issue_req(4'd3, 1'b1, 1'b0, arr_data[3], 3, t);
        mmio_req      = 1'b1;
        mmio_trace_id = 4'd0;
        spur_ack      = 4'b0001;
        @(negedge clk);
        mmio_req = 1'b0;
        @(negedge clk);
        spur_ack = 4'b0000;
        wait_idle();
        repeat (6) @(negedge clk);
        checks++;
        if (rv_cnt - rv0 !== 1) begin
            errors++;
            $display("FAIL b2b_rvalid: got %0d strobes, required 1", rv_cnt - rv0);
        end
    endtask

    task automatic test_stop();
        @(negedge clk);
        checks++;
        if (read_controls[21] !== AUTO) begin
            errors++;
            $display("FAIL stop_before: got %b, required %b", read_controls[21], AUTO);
        end
        mmio_stop = 1'b1;
        @(negedge clk);
        mmio_stop = 1'b0;
        checks++;
        if (read_controls[21] !== 1'b1) begin
            errors++;
            $display("FAIL stop_set: got %b, required 1", read_controls[21]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (read_controls[21] !== 1'b1) begin
            errors++;
            $display("FAIL stop_held: got %b, required 1", read_controls[21]);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        resp_en[1] = 1'b0;
        issue_req(4'd1, 1'b0, 1'b0, 64'd0, 0, t);
        repeat (4) @(negedge clk);
        checks++;
        if (mmio_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, required 1", mmio_busy);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        check_all_zero("after_abort");
        resp_en[1] = 1'b1;
        issue_req(4'd1, 1'b1, 1'b0, arr_data[1], 3, t);
        wait_idle();
    endtask

    initial begin
        reset_n       = 1'b0;
        mmio_req      = 1'b0;
        mmio_trace_id = 4'd0;
        mmio_stop     = 1'b0;
        resp_en       = '1;
        spur_ack      = '0;
        arr_data[0]   = 64'hA0A0_0000_1111_0000;
        arr_data[1]   = 64'hB1B1_1111_2222_1111;
        arr_data[2]   = 64'h0123_4567_89AB_CDEF;
        arr_data[3]   = 64'hC3C3_3333_4444_3333;

        test_reset();
        test_good_read();
        test_bad_id();
        test_timeout();
        test_back_to_back();
        test_stop();
        test_reset_mid();

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
